// File: rtl/conv_window_fetch_if.sv
// rtl/conv_window_fetch_if.sv - ROM address/pixel bus and window valid/ready stream
interface conv_window_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int K      = 3
);
  logic [ADDR_W-1:0] o_addr;
  logic              i_pixel;
  logic [K*K-1:0]    o_window;
  logic              o_win_valid;
  logic              i_win_ready;

  modport master (
    output o_addr, o_window, o_win_valid,
    input  i_pixel, i_win_ready
  );

  modport slave (
    input  o_addr, o_window, o_win_valid,
    output i_pixel, i_win_ready
  );
endinterface

// File: rtl/conv_window_fetch.sv
// rtl/conv_window_fetch.sv - raster-scan KxK binary window fetcher (optional WINDOW_REUSE_EN)
module conv_window_fetch #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  parameter int ADDR_W = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  conv_window_fetch_if.master bus,
  output logic o_busy,
  output logic o_done
);
  localparam int NTAP  = K * K;
  localparam int POS_W = $clog2((IMG_W > IMG_H ? IMG_W : IMG_H) + 1);
  localparam int K_W   = $clog2(NTAP + 1);

  localparam logic [POS_W-1:0] LAST_ROW     = POS_W'(IMG_H - K);
  localparam logic [POS_W-1:0] LAST_COL     = POS_W'(IMG_W - K);
  localparam logic [K_W-1:0]   LAST_TAP     = K_W'(NTAP - 1);
  localparam logic [K_W-1:0]   LAST_COL_TAP = K_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              reuse_q, reuse_d;
  logic [NTAP-1:0]   window_q, window_d;
  int                tap_kr, tap_kc, wr_idx;
  logic [ADDR_W-1:0] addr;

  // Tap geometry from registered counters only: full fetch walks row-major, reuse fetch walks the right column
  always_comb begin
    tap_kr = int'(k_q) / K;
    tap_kc = int'(k_q) % K;
    if (reuse_q) begin
      tap_kr = int'(k_q);
      tap_kc = K - 1;
    end
    wr_idx = tap_kr * K + tap_kc;
    addr   = '0;
    if (state_q != S_IDLE) begin
      addr = ADDR_W'((int'(row_q) + tap_kr) * IMG_W + int'(col_q) + tap_kc);
    end
  end

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      reuse_q  <= 1'b0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      reuse_q  <= reuse_d;
      window_q <= window_d;
    end
  end

  // Next-state: fetch taps, present the window, advance the raster position on handshake
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    reuse_d  = reuse_q;
    window_d = window_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          reuse_d = 1'b0;
        end
      end
      S_FETCH: begin
        for (int i = 0; i < NTAP; i++) begin
          if (i == wr_idx) window_d[i] = bus.i_pixel;
        end
        if (k_q == (reuse_q ? LAST_COL_TAP : LAST_TAP)) begin
          state_d = S_PRESENT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_PRESENT: begin
        if (bus.i_win_ready) begin
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            k_d     = '0;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              row_d   = row_q + POS_W'(1);
              reuse_d = 1'b0;
            end else begin
              col_d = col_q + POS_W'(1);
`ifdef WINDOW_REUSE_EN
              // Shift left one column; the right column is refetched before presenting
              reuse_d  = 1'b1;
              window_d = window_q >> 1;
`endif
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_addr      = addr;
  assign bus.o_window    = window_q;
  assign bus.o_win_valid = (state_q == S_PRESENT);
  assign o_busy          = (state_q != S_IDLE);
  assign o_done          = (state_q == S_DONE);
endmodule

// File: tb/tb_conv_window_fetch.sv
// tb/tb_conv_window_fetch.sv - randomized bench for conv_window_fetch against a raster-scan reference model
module tb_conv_window_fetch;
  localparam int K = 3;
`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic ready = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic img [32];
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  conv_window_fetch_if #(.ADDR_W(5), .K(K)) bus_a ();
  conv_window_fetch_if #(.ADDR_W(4), .K(K)) bus_b ();

  assign bus_a.i_pixel     = img[bus_a.o_addr];
  assign bus_b.i_pixel     = img[{1'b0, bus_b.o_addr}];
  assign bus_a.i_win_ready = ready;
  assign bus_b.i_win_ready = ready;

  conv_window_fetch #(.IMG_W(5), .IMG_H(5), .K(K), .ADDR_W(5)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .bus(bus_a), .o_busy(busy_a), .o_done(done_a)
  );

  conv_window_fetch #(.IMG_W(4), .IMG_H(4), .K(K), .ADDR_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .bus(bus_b), .o_busy(busy_b), .o_done(done_b)
  );

  logic       sel = 1'b0;
  logic [4:0] cur_addr;
  logic [8:0] cur_win;
  logic       cur_valid, cur_busy, cur_done;

  always_comb begin
    cur_addr  = sel ? {1'b0, bus_b.o_addr} : bus_a.o_addr;
    cur_win   = sel ? bus_b.o_window : bus_a.o_window;
    cur_valid = sel ? bus_b.o_win_valid : bus_a.o_win_valid;
    cur_busy  = sel ? busy_b : busy_a;
    cur_done  = sel ? done_b : done_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: window list and fetch-address list from the raster-scan rules
  int         img_w;
  int         exp_addr_q[$];
  logic [8:0] exp_win_q[$];
  logic [8:0] model_win0;
  int         exp_cycles, n_windows;

  task automatic build_model();
    logic [8:0] w;
    int taps;
    exp_addr_q.delete();
    exp_win_q.delete();
    exp_cycles = 0;
    n_windows  = 0;
    for (int r = 0; r <= img_w - K; r++) begin
      for (int c = 0; c <= img_w - K; c++) begin
        w = '0;
        taps = 0;
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            w[kr*K+kc] = img[(r+kr)*img_w + c + kc];
            if (!(REUSE && c > 0 && kc != K-1)) begin
              exp_addr_q.push_back((r+kr)*img_w + c + kc);
              taps++;
            end
          end
        end
        if (n_windows == 0) model_win0 = w;
        exp_win_q.push_back(w);
        exp_cycles += taps + 1;
        n_windows++;
      end
    end
  endtask

  task automatic fill_parity(input int w);
    for (int a = 0; a < 32; a++) img[a] = (((a / w) + (a % w)) % 2 == 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 32; a++) img[a] = 1'($urandom_range(0, 1));
  endtask

  // Monitor: fetch addresses, handshaken windows, stability under backpressure, done pulses
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] held_win, first_win;
  logic [4:0] held_addr;
  int         win_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cur_busy && !cur_valid && !cur_done) begin
        if (prev_stall) chk("valid_dropped", cur_valid, 1);
        chk("fetch_addr", cur_addr, exp_addr_q.size() > 0 ? exp_addr_q.pop_front() : 32'hBAD);
        prev_stall = 1'b0;
      end
      if (cur_valid) begin
        if (prev_stall) begin
          chk("stall_window", cur_win, held_win);
          chk("stall_addr", cur_addr, held_addr);
        end
        if (ready) begin
          if (win_cnt == 0) first_win = cur_win;
          chk("window", cur_win, exp_win_q.size() > 0 ? exp_win_q.pop_front() : 32'hBAD);
          win_cnt++;
        end
        prev_stall = !ready;
        held_win   = cur_win;
        held_addr  = cur_addr;
      end
      if (cur_done) done_cnt++;
    end
  end

  // mode 0: ready high, 1: random ready, 2: ready low for 6 cycles on window 0
  task automatic do_scan(input bit use_b, input int mode, input bit noise);
    int cyc, first_valid, done_at;
    bit fin;
    sel   = use_b;
    img_w = use_b ? 4 : 5;
    build_model();
    win_cnt = 0; done_cnt = 0; prev_stall = 1'b0; mon_en = 1'b1;
    ready = (mode == 0);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0; first_valid = -1; done_at = -1; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (first_valid >= 0 && cyc >= first_valid + 6);
      endcase
      if (noise && cur_busy) begin
        if (use_b) start_b = 1'($urandom_range(0, 1)); else start_a = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
      if (done_at >= 0) fin = 1'b1;
      if (cur_valid && first_valid < 0) first_valid = cyc;
      if (cur_done && done_at < 0) done_at = cyc;
      if (mode == 2 && first_valid >= 0 && cyc == first_valid + 3) begin
        chk("bp_valid", cur_valid, 1);
        chk("bp_addr", cur_addr, (K-1)*img_w + K - 1);
        chk("bp_window", cur_win, model_win0);
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    mon_en = 1'b0;
    chk("scan_done", done_at >= 0, 1);
    chk("first_valid_lat", first_valid, K*K);
    chk("win_count", win_cnt, n_windows);
    chk("done_pulses", done_cnt, 1);
    chk("addr_leftover", exp_addr_q.size(), 0);
    chk("idle_busy", cur_busy, 0);
    if (mode == 0) chk("scan_cycles", done_at, exp_cycles);
  endtask

  task automatic reset_mid();
    sel = 1'b0;
    fill_parity(5);
    mon_en = 1'b0;
    ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_addr_k4", bus_a.o_addr, 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_addr", bus_a.o_addr, 0);
    chk("rst_mid_window", bus_a.o_window, 0);
    chk("rst_mid_valid", bus_a.o_win_valid, 0);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_done", done_a, 0);
  endtask

  initial begin
    fill_parity(5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", bus_a.o_addr, 0);
    chk("rst_window", bus_a.o_window, 0);
    chk("rst_valid", bus_a.o_win_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_parity(5);
    do_scan(1'b0, 0, 1'b0);
    chk("win0_parity", first_win, 9'h155);

    fill_parity(5);
    do_scan(1'b0, 2, 1'b0);

    fill_parity(5);
    do_scan(1'b0, 0, 1'b1);

    reset_mid();
    fill_parity(5);
    do_scan(1'b0, 0, 1'b0);

    fill_parity(4);
    do_scan(1'b1, 0, 1'b0);
    chk("b_win0_parity", first_win, 9'h155);

    fill_random();
    do_scan(1'b1, 1, 1'b1);

    for (int n = 0; n < 4; n++) begin
      fill_random();
      do_scan(1'b0, 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
